buff_sequencer: RTL and testbench
=================================

# buff_sequencer

Single-clock frame sequencer that drives the `wr_toggle` / `rd_toggle` inputs of `buff_controller`. It divides the SIZE-word buffer into NFRAMES = SIZE/FRAME frames. It accepts frame-write and frame-read requests, emits the exact start and stop toggle pulses so each side moves exactly FRAME words, and tracks frame occupancy so unread data is never overwritten. It sits between the producer/consumer control logic and one `buff_controller` instance that runs with `clk_wr` = `clk_rd` = `clk`.

## Interface
- `SIZE`, 64: buffer depth in words; must equal the `buff_controller` SIZE.
- `FRAME`, 16: words per frame; at least 1; SIZE % FRAME == 0.
- `RD_LAT`, 1: memory read latency in cycles, from read-enable cycle to `data_out` valid; at least 0.
- `NFRAMES`, SIZE/FRAME: derived; not overridable.
- `clk`  in  1: single clock. One clock; reset is synchronous and active-high.
- `rst`  in  1: synchronous, active-high. Must be asserted together with `rst_wr`/`rst_rd` of the buffer.
- `wr_req`  in  1: producer requests to write one frame; level-sensitive, held until `wr_start`.
- `rd_req`  in  1: consumer requests to read one frame; level-sensitive, held until `rd_start`.
- `wr_toggle`  out  1: to `buff_controller.wr_toggle`.
- `rd_toggle`  out  1: to `buff_controller.rd_toggle`.
- `wr_start` / `rd_start`  out  1: one-cycle pulse; data moves from the next cycle on.
- `wr_done` / `rd_done`  out  1: one-cycle pulse after the last word.
- `rd_valid`  out  1: `data_out` holds a valid frame word this cycle.
- `wr_busy` / `rd_busy`  out  1: side is in START or RUN.
- `level`  out  $clog2(NFRAMES+1): written frames not yet fully read.
- `full`  out  1: level == NFRAMES.
- `empty`  out  1: level == 0.

## Operation
- Write side and read side are independent channels. Each has the same 3-state FSM: IDLE, START, RUN, plus a cycle counter of $clog2(FRAME) bits (minimum 1).
- IDLE -> START:
  - write: when `wr_req` && level < NFRAMES;
  - read: when `rd_req` && level > 0.
- START -> RUN unconditionally. The counter clears to 0.
- RUN: the counter increments each cycle. At counter == FRAME-1, go to IDLE.
- Toggle outputs are decoded from registered state only: toggle = (state==START) || (state==RUN && cnt==FRAME-1). There is no combinational path from `wr_req`/`rd_req`.
- `wr_start`/`rd_start` = state==START.
- `wr_done`/`rd_done` are registered: high in the first IDLE cycle after RUN.
- `level` updates at the edge that ends the last RUN cycle:
  - +1 on write completion;
  - −1 on read completion;
  - unchanged when both complete at the same edge.
- The frame being read stays counted in `level` until `rd_done`. This blocks its slot from being rewritten.
- `rd_valid`: a shift register of depth RD_LAT fed by the read-side buffer-enable image (state==RUN). If RUD_LAT = 0, `rd_valid` is state==RUN directly.
- Frames stay aligned because the buffer counters reset to 0, advance exactly FRAME per frame, and wrap at SIZE.
- Reset, including mid-frame:
  - both FSMs go to IDLE, counters 0, `level` 0, `rd_valid` pipeline cleared;
  - all outputs 0 except `empty` = 1.
  - The buffer enables reset in the same cycle, so toggle parity stays consistent.

## Timing
- Write request sampled high in cycle 0 while IDLE with space:
  - `wr_toggle` and `wr_start` high in cycle 1;
  - buffer write enable high in cycles 2..FRAME+1;
  - `wr_toggle` high again in cycle FRAME+1;
  - `wr_done` high and `level` incremented in cycle FRAME+2.
- Read side follows the same timing. `rd_valid` is high in cycles 2+RD_LAT..FRAME+1+RD_LAT.
- FRAME = 1: toggles in cycles 1 and 2; one enabled cycle.
- There is at least one IDLE cycle between back-to-back frames on the same side.
- A read can be granted in the cycle `wr_done` is high; its first read enable lands 2 cycles later.
- A request that arrives while the side is busy or blocked is ignored until IDLE with the condition true. No queueing beyond the held level.

## Structure
- `defines_pkg` gets `typedef enum logic [1:0] {SEQ_IDLE, SEQ_START, SEQ_RUN} seq_state_t`.
- Sub-module `buff_seq_chan`, instantiated twice (write, read):
  - ports: `clk`, `rst`, `req`, `allow`, `toggle`, `start`, `done`, `busy`, `last`;
  - `last` is high in the final RUN cycle.
- The top holds the `level` counter, `full`/`empty`, and the `rd_valid` shift register.

## Test plan
Parameters for all scenarios: SIZE=8, FRAME=4, RD_LAT=1.
- Reset with `wr_req`=`rd_req`=1 held -> all outputs 0, `empty`=1, no toggle until `rst` drops; read never starts because level=0.
- `wr_req` high in cycle 0 -> `wr_toggle` in cycles 1 and 5, `wr_start` in cycle 1, `wr_done` in cycle 6, `level`=1; buffer `wr_cntr`=4.
- `wr_req` held continuously -> two frames complete (`wr_done` in cycles 6 and 12), `full`=1; a third `wr_toggle` appears only after the first `rd_done`.
- After level=1, `rd_req` in cycle T -> `rd_toggle` in cycles T+1 and T+5, `rd_valid` in cycles T+3..T+6 with words 0..3 in order, `rd_done` in cycle T+6, `level`=0.
- Write and read arranged to finish at the same edge -> `wr_done` and `rd_done` in the same cycle, `level` unchanged at 1.
- `rst` asserted in cycle 3 of a write RUN -> next cycle all FSMs IDLE, `level`=0, `wr_toggle`=0; a fresh `wr_req` writes from address 0.

Source files
------------

// File: rtl/defines_pkg.sv
// Shared types for the buffer frame sequencer.
package defines_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_START = 2'd1,
      SEQ_RUN   = 2'd2
   } seq_state_t;

   // Counter width that never collapses to zero bits.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/buff_seq_chan.sv
// One sequencing channel: turns a held request into a start toggle, FRAME
// enabled cycles and a stop toggle. All outputs come straight from flops.
module buff_seq_chan
   import defines_pkg::*;
#(
   parameter int unsigned FRAME = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic allow,
   output logic toggle,
   output logic start,
   output logic done,
   output logic busy,
   output logic last
);

   localparam int unsigned CNT_W = clog2_min1(FRAME);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

   seq_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic toggle_q, toggle_d;
   logic start_q, start_d;
   logic done_q, done_d;
   logic busy_q, busy_d;
   logic last_q, last_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= SEQ_IDLE;
         cnt_q    <= '0;
         toggle_q <= 1'b0;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         toggle_q <= toggle_d;
         start_q  <= start_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         last_q   <= last_d;
      end
   end

   // Next state; outputs are decoded from the next state so they register cleanly.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         SEQ_IDLE: begin
            cnt_d = '0;
            if (req && allow) state_d = SEQ_START;
         end
         SEQ_START: begin
            state_d = SEQ_RUN;
            cnt_d   = '0;
         end
         SEQ_RUN: begin
            if (cnt_q == CNT_LAST) begin
               state_d = SEQ_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = SEQ_IDLE;
            cnt_d   = '0;
         end
      endcase

      last_d   = (state_d == SEQ_RUN) && (cnt_d == CNT_LAST);
      start_d  = (state_d == SEQ_START);
      toggle_d = start_d || last_d;
      busy_d   = (state_d != SEQ_IDLE);
      done_d   = (state_q == SEQ_RUN) && (cnt_q == CNT_LAST);
   end

   assign toggle = toggle_q;
   assign start  = start_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign last   = last_q;

endmodule

// File: rtl/buff_sequencer.sv
// Frame sequencer for buff_controller: write/read channels plus frame
// occupancy tracking so a frame is never overwritten before it is read.
module buff_sequencer
   import defines_pkg::*;
#(
   parameter  int unsigned SIZE    = 64,
   parameter  int unsigned FRAME   = 16,
   parameter  int unsigned RD_LAT  = 1,
   localparam int unsigned NFRAMES = SIZE / FRAME,
   localparam int unsigned LVL_W   = $clog2(NFRAMES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_req,
   input  logic             rd_req,
   output logic             wr_toggle,
   output logic             rd_toggle,
   output logic             wr_start,
   output logic             rd_start,
   output logic             wr_done,
   output logic             rd_done,
   output logic             rd_valid,
   output logic             wr_busy,
   output logic             rd_busy,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   logic wr_last, rd_last;
   logic wr_allow_c, rd_allow_c;
   logic rd_run_c;
   logic [LVL_W-1:0] level_q, level_d;
   logic full_q, full_d;
   logic empty_q, empty_d;

   assign wr_allow_c = (level_q < LVL_W'(NFRAMES));
   assign rd_allow_c = (level_q != '0);

   buff_seq_chan #(.FRAME(FRAME)) u_wr_chan (
      .clk    (clk),
      .rst    (rst),
      .req    (wr_req),
      .allow  (wr_allow_c),
      .toggle (wr_toggle),
      .start  (wr_start),
      .done   (wr_done),
      .busy   (wr_busy),
      .last   (wr_last)
   );

   buff_seq_chan #(.FRAME(FRAME)) u_rd_chan (
      .clk    (clk),
      .rst    (rst),
      .req    (rd_req),
      .allow  (rd_allow_c),
      .toggle (rd_toggle),
      .start  (rd_start),
      .done   (rd_done),
      .busy   (rd_busy),
      .last   (rd_last)
   );

   // A frame under read stays counted until its last word, protecting its slot.
   always_comb begin
      level_d = level_q;
      unique case ({wr_last, rd_last})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      full_d  = (level_d == LVL_W'(NFRAMES));
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         level_q <= level_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   assign level = level_q;
   assign full  = full_q;
   assign empty = empty_q;

   // Read-enable image of the buffer: RUN cycles of the read channel.
   assign rd_run_c = rd_busy && !rd_start;

   generate
      if (RD_LAT == 0) begin : g_no_lat
         assign rd_valid = rd_run_c;
      end else begin : g_lat
         logic [RD_LAT-1:0] vld_q, vld_d;

         always_comb begin
            vld_d    = vld_q << 1;
            vld_d[0] = rd_run_c;
         end

         always_ff @(posedge clk) begin
            if (rst) vld_q <= '0;
            else     vld_q <= vld_d;
         end

         assign rd_valid = vld_q[RD_LAT-1];
      end
   endgenerate

endmodule

// File: tb/tb_buff_sequencer.sv
// Directed bench for buff_sequencer with a small toggle-driven buffer model.
module tb_buff_sequencer;

   localparam int unsigned SIZE   = 8;
   localparam int unsigned FRAME  = 4;
   localparam int unsigned RD_LAT = 1;

   logic       clk;
   logic       rst;
   logic       wr_req;
   logic       rd_req;
   logic       wr_toggle, rd_toggle;
   logic       wr_start, rd_start;
   logic       wr_done, rd_done;
   logic       rd_valid;
   logic       wr_busy, rd_busy;
   logic [1:0] level;
   logic       full, empty;

   int errors;
   int checks;

   buff_sequencer #(.SIZE(SIZE), .FRAME(FRAME), .RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_req    (wr_req),
      .rd_req    (rd_req),
      .wr_toggle (wr_toggle),
      .rd_toggle (rd_toggle),
      .wr_start  (wr_start),
      .rd_start  (rd_start),
      .wr_done   (wr_done),
      .rd_done   (rd_done),
      .rd_valid  (rd_valid),
      .wr_busy   (wr_busy),
      .rd_busy   (rd_busy),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Buffer model: enables flip on each toggle, counters wrap at SIZE, one-cycle read latency.
   logic       wr_en, rd_en;
   logic [2:0] wr_cntr, rd_cntr;
   logic [7:0] wr_word, data_out;
   logic [7:0] mem [0:7];

   always @(posedge clk) begin
      if (rst) begin
         wr_en    <= 1'b0;
         rd_en    <= 1'b0;
         wr_cntr  <= 3'd0;
         rd_cntr  <= 3'd0;
         wr_word  <= 8'd0;
         data_out <= 8'd0;
      end else begin
         wr_en <= wr_en ^ wr_toggle;
         rd_en <= rd_en ^ rd_toggle;
         if (wr_en) begin
            mem[wr_cntr] <= wr_word;
            wr_cntr      <= wr_cntr + 3'd1;
            wr_word      <= wr_word + 8'd1;
         end
         if (rd_en) begin
            data_out <= mem[rd_cntr];
            rd_cntr  <= rd_cntr + 3'd1;
         end
      end
   end

   logic [12:0] outs;
   assign outs = {wr_toggle, rd_toggle, wr_start, rd_start, wr_done, rd_done,
                  rd_valid, wr_busy, rd_busy, full, empty, level};
   localparam logic [12:0] OUTS_RST = 13'b0000000000100;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Request a frame on either/both sides in the current cycle and check cycles 1..6.
   task automatic frame(input bit w, input bit r, input int base);
      if (w) wr_req = 1'b1;
      if (r) rd_req = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i == 1) begin
            if (w) wr_req = 1'b0;
            if (r) rd_req = 1'b0;
         end
         if (w) begin
            check("wr_toggle", 32'(wr_toggle), 32'(i == 1 || i == 5));
            check("wr_start",  32'(wr_start),  32'(i == 1));
            check("wr_done",   32'(wr_done),   32'(i == 6));
         end
         if (r) begin
            check("rd_toggle", 32'(rd_toggle), 32'(i == 1 || i == 5));
            check("rd_start",  32'(rd_start),  32'(i == 1));
            check("rd_done",   32'(rd_done),   32'(i == 6));
            check("rd_valid",  32'(rd_valid),  32'(i >= 3));
            if (i >= 3) check("rd_data", 32'(data_out), 32'(base + i - 3));
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      wr_req = 1'b1;
      rd_req = 1'b1;

      // Reset with both requests held.
      repeat (3) begin
         step();
         check("reset_outs", 32'(outs), 32'(OUTS_RST));
      end
      rst    = 1'b0;
      wr_req = 1'b0;
      repeat (4) begin
         step();
         check("rd_blocked_empty", 32'({rd_toggle, rd_busy}), 32'd0);
      end
      rd_req = 1'b0;

      // Single write frame.
      frame(1'b1, 1'b0, 0);
      check("level_after_w1", 32'(level), 32'd1);
      check("wr_cntr_after_w1", 32'(wr_cntr), 32'd4);
      check("empty_after_w1", 32'(empty), 32'd0);

      // Single read frame: words 0..3.
      frame(1'b0, 1'b1, 0);
      check("level_after_r1", 32'(level), 32'd0);
      check("empty_after_r1", 32'(empty), 32'd1);

      // Continuous write request until full.
      wr_req = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step();
         check("cont_wr_toggle", 32'(wr_toggle), 32'(i == 1 || i == 5 || i == 7 || i == 11));
         check("cont_wr_done",   32'(wr_done),   32'(i == 6 || i == 12));
         if (i == 6) check("cont_level_mid", 32'(level), 32'd1);
      end
      check("cont_level_full", 32'(level), 32'd2);
      check("cont_full", 32'(full), 32'd1);
      repeat (4) begin
         step();
         check("full_blocks_wr", 32'({wr_toggle, wr_busy}), 32'd0);
      end

      // Read frees a slot; held write restarts right after rd_done.
      frame(1'b0, 1'b1, 4);
      check("level_after_free", 32'(level), 32'd1);
      check("full_after_free", 32'(full), 32'd0);
      check("wr_wait_rd_done", 32'(wr_toggle), 32'd0);
      step();
      check("third_wr_toggle", 32'(wr_toggle), 32'd1);
      check("third_wr_start", 32'(wr_start), 32'd1);
      wr_req = 1'b0;
      for (int i = 8; i <= 12; i++) begin
         step();
         if (i == 11) check("third_wr_stop", 32'(wr_toggle), 32'd1);
      end
      check("third_wr_done", 32'(wr_done), 32'd1);
      check("third_level", 32'(level), 32'd2);

      // Drain one frame, then write and read finishing together.
      frame(1'b0, 1'b1, 8);
      check("level_before_sim", 32'(level), 32'd1);
      frame(1'b1, 1'b1, 12);
      check("level_sim_done", 32'(level), 32'd1);
      check("wr_cntr_sim", 32'(wr_cntr), 32'd4);

      // Reset in the third RUN cycle of a write.
      wr_req = 1'b1;
      step();
      wr_req = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      check("midframe_rst_outs", 32'(outs), 32'(OUTS_RST));
      check("midframe_rst_cntr", 32'(wr_cntr), 32'd0);
      rst = 1'b0;
      frame(1'b1, 1'b0, 0);
      check("fresh_wr_cntr", 32'(wr_cntr), 32'd4);
      check("fresh_mem0", 32'(mem[0]), 32'd0);
      check("fresh_mem3", 32'(mem[3]), 32'd3);
      check("fresh_level", 32'(level), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
